debug_slave_jtag_master: RTL and testbench
==========================================

// Module: debug_slave_jtag_master
// PURPOSE
// - Initiator end of the Nios II debug-slave virtual-JTAG link; drives the vji_* signal set the debug slave consumes.
// - Turns one host command (IR value + DR word) into a full cycle: UIR, CDR, SDR (shift), UDR, RTI.
// - Captures the slave's shifted-out DR word and returns it on a valid/ready response port.
// - Used as a sim/test host and as an on-chip debug bridge.
// PARAMETERS
// IR_LEN      2   width of vji_ir_in / cmd_ir
// DR_LEN      38  shifted DR length (matches jdo/sr width)
// CLK_DIV     2   clk cycles per TCK half-period; legal range >=1
// RTI_CYCLES  2   TCK periods spent in run-test-idle after UDR; legal range >=1
// PORTS
// clk          in   1        system clock; all logic on rising edge
// reset        in   1        synchronous, active-high reset
// cmd_valid    in   1        command request
// cmd_ready    out  1        command accepted when cmd_valid&&cmd_ready
// cmd_ir       in   IR_LEN   instruction for this transaction
// cmd_dr       in   DR_LEN   data word to shift in, LSB first
// rsp_valid    out  1        response available
// rsp_ready    in   1        response consumed when rsp_valid&&rsp_ready
// rsp_dr       out  DR_LEN   word shifted out of the slave
// vji_tck      out  1        generated TCK
// vji_tdi      out  1        serial data to slave
// vji_tdo      in   1        serial data from slave
// vji_ir_in    out  IR_LEN   current instruction
// vji_uir      out  1        virtual update-IR strobe
// vji_cdr      out  1        virtual capture-DR strobe
// vji_sdr      out  1        virtual shift-DR strobe
// vji_udr      out  1        virtual update-DR strobe
// vji_rti      out  1        run-test-idle indicator
// BEHAVIOUR
// - Reset: state=IDLE; div_cnt=0; cmd_ready=0 during reset then 1; all other outputs 0, including rsp_dr and vji_ir_in.
// - TCK generation:
//   - div_cnt runs 0..2*CLK_DIV-1 only outside IDLE/RESP.
//   - vji_tck=(div_cnt>=CLK_DIV).
//   - Held low in IDLE and RESP.
// - Tick boundary: div_cnt wraps to 0, which is the TCK falling edge.
//   - vji_tdi and all vji_* strobes are registered and change only at a tick boundary.
//   - One state dwell unit is one TCK period.
// - TDO sample: taken on the clk where div_cnt==CLK_DIV-1, i.e. the last clk before the TCK rising edge.
//   - Applies only in SHIFT.
//   - rsp_shift <= {vji_tdo, rsp_shift[DR_LEN-1:1]}.
// - FSM: IDLE -> UIR(1) -> CDR(1) -> SHIFT(DR_LEN) -> UDR(1) -> RTI(RTI_CYCLES) -> RESP. Bracketed figures are dwell in TCK periods.
//   - IDLE: cmd_ready=1; on handshake latch cmd_ir/cmd_dr, clear rsp_shift, enter UIR with div_cnt=0.
//   - UIR: vji_uir=1; vji_ir_in<=cmd_ir. vji_ir_in holds this value until the next UIR.
//   - CDR: vji_cdr=1.
//   - SHIFT: vji_sdr=1; vji_tdi=dr_shift[0]. At each tick boundary dr_shift>>=1. bit_cnt counts DR_LEN ticks, then exit.
//   - UDR: vji_udr=1; vji_tdi=0.
//   - RTI: vji_rti=1 for RTI_CYCLES periods.
//   - RESP: rsp_valid=1 and rsp_dr=rsp_shift, held stable until rsp_ready. Then go to IDLE on the next clk.
// - Strobe exclusivity: exactly one of uir/cdr/sdr/udr/rti is high in UIR..RTI. All are 0 in IDLE/RESP.
// - Latency:
//   - Handshake at cycle 0 gives rsp_valid at cycle 1+2*CLK_DIV*(DR_LEN+RTI_CYCLES+3).
//   - With defaults that is cycle 173.
//   - Exactly DR_LEN+RTI_CYCLES+3 TCK rising edges occur per transaction.
// - Flow control:
//   - cmd_ready=0 in every state except IDLE; cmd_valid while busy is ignored (not queued).
//   - rsp_ready and rsp_valid high in the same clk complete the transaction; cmd_ready=1 on the next clk.
// - Reset mid-transaction (any state): next clk is IDLE with tck low and all strobes 0.
//   - No rsp_valid is produced and partial data is discarded.
// - CLK_DIV=1: TCK=clk/2; the TDO sample and the tick boundary fall on adjacent clks. Required to work.
// TESTING
// - Bench target model: DR_LEN shift register on posedge vji_tck while vji_sdr, shifting {tdi,sr[DR_LEN-1:1]}; tdo=sr[0].
// - Loopback: model preloaded 38'h2A_5555_AAAA; cmd_dr=38'h15_0F0F_F0F0, cmd_ir=2'b01.
//   -> rsp_dr=38'h2A_5555_AAAA; model sr=38'h15_0F0F_F0F0 at the udr strobe.
// - Timing: handshake at cycle 0 with defaults -> rsp_valid first high at cycle 173.
//   -> Exactly 43 vji_tck rising edges; vji_sdr high across exactly 38 of them.
// - Backpressure: rsp_ready=0 for 20 clks -> rsp_valid/rsp_dr stable, cmd_ready=0.
//   -> cmd_valid during that window not accepted. After rsp_ready=1, cmd_ready=1 next clk.
// - IR update: back-to-back cmds with cmd_ir=2'b10 then 2'b11.
//   -> vji_uir pulses once per cmd; vji_ir_in 2'b10 persists through the first RESP, then 2'b11.
// - Reset in SHIFT after 10 ticks.
//   -> Next clk: all vji_* =0, cmd_ready=1, no rsp_valid.
//   -> A fresh loopback cmd then passes with correct data.
// - CLK_DIV=1, RTI_CYCLES=1: loopback of 38'h3F_FFFF_FFFF returns the model preload.
//   -> rsp_valid at cycle 1+2*(42)=85.

Source files
------------

// File: rtl/debug_slave_jtag_master.sv
// Initiator end of the Nios II debug-slave virtual-JTAG link.
// Runs one host command (IR + DR word) through UIR, CDR, SHIFT, UDR and RTI,
// then returns the word shifted out of the slave on a valid/ready port.
module debug_slave_jtag_master #(
  parameter int IR_LEN     = 2,
  parameter int DR_LEN     = 38,
  parameter int CLK_DIV    = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IR_LEN-1:0] cmd_ir,
  input  logic [DR_LEN-1:0] cmd_dr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DR_LEN-1:0] rsp_dr,
  output logic              vji_tck,
  output logic              vji_tdi,
  input  logic              vji_tdo,
  output logic [IR_LEN-1:0] vji_ir_in,
  output logic              vji_uir,
  output logic              vji_cdr,
  output logic              vji_sdr,
  output logic              vji_udr,
  output logic              vji_rti
);

  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam int BIT_W = $clog2(DR_LEN + 1);
  localparam int RTI_W = $clog2(RTI_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_SAMPLE = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DR_LEN - 1);
  localparam logic [RTI_W-1:0] RTI_LAST   = RTI_W'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [RTI_W-1:0]  rti_cnt;
  logic [DR_LEN-1:0] dr_shift;
  logic [DR_LEN-1:0] rsp_shift;
  logic              running;
  logic              tick;
  logic              sample;
  logic              accept;

  // TCK only runs while a transaction is between UIR and RTI; a tick is the
  // wrap of the divider, which is also the TCK falling edge.
  assign running = (state != IDLE) && (state != RESP);
  assign tick    = running && (div_cnt == DIV_LAST);
  assign div_nxt = tick ? '0 : div_cnt + 1'b1;
  // TDO is taken on the last clk before TCK rises, matching the slave's
  // capture point for the bit it currently presents.
  assign sample  = (state == SHIFT) && (div_cnt == DIV_SAMPLE);
  assign accept  = (state == IDLE) && cmd_valid && cmd_ready;

  // Sequencer: state, divider, registered TCK and all registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      vji_tck   <= 1'b0;
      bit_cnt   <= '0;
      rti_cnt   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dr    <= '0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
      vji_uir   <= 1'b0;
      vji_cdr   <= 1'b0;
      vji_sdr   <= 1'b0;
      vji_udr   <= 1'b0;
      vji_rti   <= 1'b0;
    end else begin
      div_cnt <= running ? div_nxt : '0;
      vji_tck <= running && (div_nxt >= DIV_HALF);
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            vji_ir_in <= cmd_ir;
            vji_uir   <= 1'b1;
            state     <= UIR;
          end
        end
        UIR: if (tick) begin
          vji_uir <= 1'b0;
          vji_cdr <= 1'b1;
          state   <= CDR;
        end
        CDR: if (tick) begin
          vji_cdr <= 1'b0;
          vji_sdr <= 1'b1;
          vji_tdi <= dr_shift[0];
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: if (tick) begin
          if (bit_cnt == BIT_LAST) begin
            vji_sdr <= 1'b0;
            vji_tdi <= 1'b0;
            vji_udr <= 1'b1;
            state   <= UDR;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            vji_tdi <= dr_shift[0];
          end
        end
        UDR: if (tick) begin
          vji_udr <= 1'b0;
          vji_rti <= 1'b1;
          rti_cnt <= '0;
          state   <= RTI;
        end
        RTI: if (tick) begin
          if (rti_cnt == RTI_LAST) begin
            vji_rti   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_dr    <= rsp_shift;
            state     <= RESP;
          end else begin
            rti_cnt <= rti_cnt + 1'b1;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift datapath: outgoing word drains LSB first, incoming bits enter at the MSB.
  always_ff @(posedge clk) begin
    if (accept) begin
      dr_shift  <= cmd_dr;
      rsp_shift <= '0;
    end else begin
      if (tick && ((state == CDR) || (state == SHIFT))) dr_shift <= dr_shift >> 1;
      if (sample) rsp_shift <= {vji_tdo, rsp_shift[DR_LEN-1:1]};
    end
  end

endmodule

// File: tb/tb_debug_slave_jtag_master.sv
// Bench for debug_slave_jtag_master: two instances (default timing and
// CLK_DIV=1/RTI_CYCLES=1), each wired to a behavioural debug-slave DR model.
module tb_debug_slave_jtag_master;

  localparam int IRL = 2;
  localparam int DRL = 38;

  logic clk;
  logic reset;
  logic [1:0] cmd_valid;
  logic [1:0] rsp_ready;
  logic [1:0] load;
  logic [1:0][IRL-1:0] cmd_ir;
  logic [1:0][DRL-1:0] cmd_dr;
  logic [DRL-1:0] pre;

  wire [1:0] cmd_ready, rsp_valid, tck, tdi, tdo, uir, cdr, sdr, udr, rti;
  wire [1:0][DRL-1:0] rsp_dr;
  wire [1:0][IRL-1:0] ir_in;

  logic [DRL-1:0] sr0, sr1, sr_udr0, sr_udr1;
  int tck_n0, sdr_n0, uir_n0, tck_n1, sdr_n1, uir_n1;
  int cyc;
  int excl_bad;
  int nchk, nfail;

  typedef struct {
    logic [IRL-1:0] ir;
    logic [DRL-1:0] dr;
    logic [DRL-1:0] pl;
    logic [DRL-1:0] exp_rsp;
    logic [DRL-1:0] exp_sr;
  } vec_t;

  vec_t tbl [5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  debug_slave_jtag_master #(.IR_LEN(IRL), .DR_LEN(DRL), .CLK_DIV(2), .RTI_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_ir(cmd_ir[0]), .cmd_dr(cmd_dr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_dr(rsp_dr[0]),
    .vji_tck(tck[0]), .vji_tdi(tdi[0]), .vji_tdo(tdo[0]), .vji_ir_in(ir_in[0]),
    .vji_uir(uir[0]), .vji_cdr(cdr[0]), .vji_sdr(sdr[0]), .vji_udr(udr[0]), .vji_rti(rti[0])
  );

  debug_slave_jtag_master #(.IR_LEN(IRL), .DR_LEN(DRL), .CLK_DIV(1), .RTI_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_ir(cmd_ir[1]), .cmd_dr(cmd_dr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_dr(rsp_dr[1]),
    .vji_tck(tck[1]), .vji_tdi(tdi[1]), .vji_tdo(tdo[1]), .vji_ir_in(ir_in[1]),
    .vji_uir(uir[1]), .vji_cdr(cdr[1]), .vji_sdr(sdr[1]), .vji_udr(udr[1]), .vji_rti(rti[1])
  );

  // Slave DR models: shift on TCK rise while shift-DR is active, present sr[0].
  assign tdo = {sr1[0], sr0[0]};

  always @(posedge tck[0] or posedge load[0])
    if (load[0]) sr0 <= pre;
    else if (sdr[0]) sr0 <= {tdi[0], sr0[DRL-1:1]};

  always @(posedge tck[1] or posedge load[1])
    if (load[1]) sr1 <= pre;
    else if (sdr[1]) sr1 <= {tdi[1], sr1[DRL-1:1]};

  always @(posedge tck[0]) begin
    tck_n0 <= tck_n0 + 1;
    if (sdr[0]) sdr_n0 <= sdr_n0 + 1;
  end

  always @(posedge tck[1]) begin
    tck_n1 <= tck_n1 + 1;
    if (sdr[1]) sdr_n1 <= sdr_n1 + 1;
  end

  always @(posedge uir[0]) uir_n0 <= uir_n0 + 1;
  always @(posedge uir[1]) uir_n1 <= uir_n1 + 1;
  always @(posedge udr[0]) sr_udr0 <= sr0;
  always @(posedge udr[1]) sr_udr1 <= sr1;

  // Strobe sanity: never two strobes at once; all quiet with TCK low when idle or responding.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        if ($countones({uir[d], cdr[d], sdr[d], udr[d], rti[d]}) > 1) excl_bad++;
        if ((rsp_valid[d] || cmd_ready[d]) && ({uir[d], cdr[d], sdr[d], udr[d], rti[d], tck[d]} != 6'b0))
          excl_bad++;
      end
    end
  end

  function automatic int get_tck(input int d);
    return (d == 0) ? tck_n0 : tck_n1;
  endfunction

  function automatic int get_sdr(input int d);
    return (d == 0) ? sdr_n0 : sdr_n1;
  endfunction

  function automatic int get_uir(input int d);
    return (d == 0) ? uir_n0 : uir_n1;
  endfunction

  function automatic logic [DRL-1:0] get_srudr(input int d);
    return (d == 0) ? sr_udr0 : sr_udr1;
  endfunction

  function automatic logic [DRL-1:0] rnd_dr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DRL-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One full command on instance d; hold>0 keeps rsp_ready low that many clks
  // while a competing command is offered.
  task automatic xact(input int d, input logic [IRL-1:0] ir, input logic [DRL-1:0] dr,
                      input logic [DRL-1:0] pl, input logic [DRL-1:0] exp_rsp,
                      input logic [DRL-1:0] exp_sr, input int hold);
    int n, t0, lat, tck_b, sdr_b, uir_b, exp_edges, exp_lat, div;
    logic [DRL-1:0] held;
    div       = (d == 0) ? 2 : 1;
    exp_edges = DRL + ((d == 0) ? 2 : 1) + 3;
    exp_lat   = 1 + 2 * div * exp_edges;
    n = 0;
    while (!cmd_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before", cmd_ready[d], 1);
    pre = pl;
    load[d] = 1'b1;
    #1;
    load[d] = 1'b0;
    tck_b = get_tck(d);
    sdr_b = get_sdr(d);
    uir_b = get_uir(d);
    cmd_ir[d] = ir;
    cmd_dr[d] = dr;
    cmd_valid[d] = 1'b1;
    t0 = cyc;
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    check("cmd_ready_busy", cmd_ready[d], 0);
    n = 0;
    while (!rsp_valid[d] && n < 400) begin
      @(negedge clk);
      n++;
    end
    lat = rsp_valid[d] ? (cyc - t0) : -1;
    check("latency", lat, exp_lat);
    check("tck_edges", get_tck(d) - tck_b, exp_edges);
    check("sdr_edges", get_sdr(d) - sdr_b, DRL);
    check("uir_pulses", get_uir(d) - uir_b, 1);
    check("rsp_dr", rsp_dr[d], exp_rsp);
    check("slave_sr_at_udr", get_srudr(d), exp_sr);
    check("ir_in_resp", ir_in[d], ir);
    held = rsp_dr[d];
    if (hold > 0) begin
      cmd_ir[d] = ~ir;
      cmd_dr[d] = ~dr;
      cmd_valid[d] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("bp_rsp_valid", rsp_valid[d], 1);
        check("bp_rsp_dr", rsp_dr[d], held);
        check("bp_cmd_ready", cmd_ready[d], 0);
      end
      cmd_valid[d] = 1'b0;
      check("bp_no_accept", get_uir(d) - uir_b, 1);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check("rsp_done", rsp_valid[d], 0);
    check("cmd_ready_after", cmd_ready[d], 1);
  endtask

  initial begin
    int base_sdr, n, uir_b;
    bit seen;
    logic [DRL-1:0] r_dr, r_pl;
    logic [IRL-1:0] r_ir;
    reset = 1'b1;
    cmd_valid = '0;
    rsp_ready = '0;
    load = '0;
    cmd_ir = '0;
    cmd_dr = '0;
    pre = '0;
    nchk = 0;
    nfail = 0;

    tbl[0] = '{2'b01, 38'h15_0F0F_F0F0, 38'h2A_5555_AAAA, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0};
    tbl[1] = '{2'b00, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF, 38'h00_0000_0000};
    tbl[2] = '{2'b11, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 38'h00_0000_0000, 38'h3F_FFFF_FFFF};
    tbl[3] = '{2'b10, 38'h20_0000_0001, 38'h00_0000_0001, 38'h00_0000_0001, 38'h20_0000_0001};
    tbl[4] = '{2'b01, 38'h12_3456_789A, 38'h20_0000_0000, 38'h20_0000_0000, 38'h12_3456_789A};

    // Reset state on both instances.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_cmd_ready", cmd_ready[d], 0);
      check("rst_rsp_valid", rsp_valid[d], 0);
      check("rst_rsp_dr", rsp_dr[d], 0);
      check("rst_vji", {tck[d], tdi[d], uir[d], cdr[d], sdr[d], udr[d], rti[d], ir_in[d]}, 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) check("post_rst_cmd_ready", cmd_ready[d], 1);

    // Table-driven loopback on the default-timing instance.
    for (int i = 0; i < 5; i++)
      xact(0, tbl[i].ir, tbl[i].dr, tbl[i].pl, tbl[i].exp_rsp, tbl[i].exp_sr, 0);

    // Randomised loopback: the slave's old contents come back, the command word stays behind.
    for (int i = 0; i < 6; i++) begin
      r_dr = rnd_dr();
      r_pl = rnd_dr();
      r_ir = IRL'($urandom_range(0, 3));
      xact(0, r_ir, r_dr, r_pl, r_pl, r_dr, 0);
    end

    // Backpressure with a competing command offered while the response is held.
    xact(0, 2'b01, 38'h15_0F0F_F0F0, 38'h2A_5555_AAAA, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0, 20);

    // IR update: back-to-back commands, instruction persists between them.
    uir_b = uir_n0;
    xact(0, 2'b10, 38'h01_2345_6789, 38'h3A_BCDE_F012, 38'h3A_BCDE_F012, 38'h01_2345_6789, 0);
    check("ir_hold_idle", ir_in[0], 2'b10);
    check("uir_once_first", uir_n0 - uir_b, 1);
    xact(0, 2'b11, 38'h0F_0000_FFFF, 38'h30_FFFF_0000, 38'h30_FFFF_0000, 38'h0F_0000_FFFF, 0);
    check("ir_second", ir_in[0], 2'b11);
    check("uir_once_each", uir_n0 - uir_b, 2);

    // Reset during SHIFT after 10 shift ticks.
    pre = 38'h2A_5555_AAAA;
    load[0] = 1'b1;
    #1;
    load[0] = 1'b0;
    base_sdr = sdr_n0;
    cmd_ir[0] = 2'b01;
    cmd_dr[0] = 38'h15_0F0F_F0F0;
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    n = 0;
    while ((sdr_n0 - base_sdr) < 10 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("shift_reached", sdr[0], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_vji", {tck[0], tdi[0], uir[0], cdr[0], sdr[0], udr[0], rti[0]}, 0);
    check("midrst_rsp_valid", rsp_valid[0], 0);
    @(negedge clk);
    check("midrst_cmd_ready", cmd_ready[0], 1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid[0] || tck[0]) seen = 1'b1;
    end
    check("midrst_quiet", seen, 0);
    xact(0, 2'b01, 38'h15_0F0F_F0F0, 38'h2A_5555_AAAA, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0, 0);

    // Fastest divider with a single RTI period.
    xact(1, 2'b01, 38'h3F_FFFF_FFFF, 38'h2A_5555_AAAA, 38'h2A_5555_AAAA, 38'h3F_FFFF_FFFF, 0);
    for (int i = 0; i < 3; i++) begin
      r_dr = rnd_dr();
      r_pl = rnd_dr();
      xact(1, 2'b10, r_dr, r_pl, r_pl, r_dr, 0);
    end
    xact(1, 2'b11, 38'h15_0F0F_F0F0, 38'h2A_5555_AAAA, 38'h2A_5555_AAAA, 38'h15_0F0F_F0F0, 5);

    check("strobe_exclusive", excl_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
